// File: rtl/mul_bus_master.sv
//==============================================================================
// mul_bus_master - runs one 64x64 multiply job at a time on the Multiplier
// slave bus and returns the 128-bit product (or a timeout error). Rev 1.0
//==============================================================================
`default_nettype none

module mul_bus_master #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cmd_valid,
   input  logic [63:0]  cmd_a,
   input  logic [63:0]  cmd_b,
   output logic         cmd_ready,
   output logic         M_sel,
   output logic         M_wr,
   output logic [7:0]   M_address,
   output logic [31:0]  M_dout,
   input  logic [31:0]  M_din,
   input  logic         m_interrupt,
   output logic         res_valid,
   output logic [127:0] res_data,
   output logic         res_err,
   input  logic         res_ready
);

   localparam int            CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [7:0] ADDR_A_LO  = 8'h00;
   localparam logic [7:0] ADDR_A_HI  = 8'h01;
   localparam logic [7:0] ADDR_B_LO  = 8'h02;
   localparam logic [7:0] ADDR_B_HI  = 8'h03;
   localparam logic [7:0] ADDR_RES0  = 8'h04;
   localparam logic [7:0] ADDR_START = 8'h08;
   localparam logic [7:0] ADDR_CLEAR = 8'h09;
   localparam logic [7:0] ADDR_IE    = 8'h0a;
   localparam logic [7:0] ADDR_ICLR  = 8'h0b;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_A0, S_WR_A1, S_WR_B0, S_WR_B1, S_WR_IE, S_START,
      S_WAIT, S_RD, S_INTCLR, S_ABORT, S_OUT
   } state_t;

   state_t         state_q, state_d;
   logic [63:0]    a_q, a_d;
   logic [63:0]    b_q, b_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     rd_idx_q, rd_idx_d;
   logic           cap_q, cap_d;
   logic [1:0]     cap_idx_q, cap_idx_d;
   logic           cmd_ready_q, cmd_ready_d;
   logic           sel_q, sel_d;
   logic           wr_q, wr_d;
   logic [7:0]     addr_q, addr_d;
   logic [31:0]    dout_q, dout_d;
   logic           res_valid_q, res_valid_d;
   logic           res_err_q, res_err_d;
   logic [127:0]   res_data_q, res_data_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         rd_idx_q    <= '0;
         cap_q       <= 1'b0;
         cap_idx_q   <= '0;
         cmd_ready_q <= 1'b0;
         sel_q       <= 1'b0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         dout_q      <= '0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cnt_q       <= cnt_d;
         rd_idx_q    <= rd_idx_d;
         cap_q       <= cap_d;
         cap_idx_q   <= cap_idx_d;
         cmd_ready_q <= cmd_ready_d;
         sel_q       <= sel_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         res_valid_q <= res_valid_d;
         res_err_q   <= res_err_d;
         res_data_q  <= res_data_d;
      end
   end

   // Next state, operand latch, timeout counter and result capture.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      cnt_d      = cnt_q;
      rd_idx_d   = rd_idx_q;
      res_err_d  = res_err_q;
      res_data_d = res_data_q;
      // Read data trails its address by one cycle, so capture is a delayed copy of RD.
      cap_d      = (state_q == S_RD);
      cap_idx_d  = rd_idx_q;
      if (cap_q) begin
         res_data_d[{cap_idx_q, 5'd0} +: 32] = M_din;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               a_d        = cmd_a;
               b_d        = cmd_b;
               res_data_d = '0;
               res_err_d  = 1'b0;
               state_d    = S_WR_A0;
            end
         end
         S_WR_A0: state_d = S_WR_A1;
         S_WR_A1: state_d = S_WR_B0;
         S_WR_B0: state_d = S_WR_B1;
         S_WR_B1: state_d = S_WR_IE;
         S_WR_IE: state_d = S_START;
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (m_interrupt) begin
               cnt_d    = '0;
               rd_idx_d = '0;
               state_d  = S_RD;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RD: begin
            if (rd_idx_q == 2'd3) begin
               state_d = S_INTCLR;
            end else begin
               rd_idx_d = rd_idx_q + 2'd1;
            end
         end
         S_INTCLR: state_d = S_OUT;
         S_ABORT: begin
            res_err_d  = 1'b1;
            res_data_d = '0;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (res_ready) begin
               res_err_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bus and handshake outputs are decoded from the state being entered so they register cleanly.
   always_comb begin
      sel_d       = 1'b0;
      wr_d        = 1'b0;
      addr_d      = '0;
      dout_d      = '0;
      cmd_ready_d = (state_d == S_IDLE);
      res_valid_d = (state_d == S_OUT);

      case (state_d)
         S_WR_A0: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_A_LO;
            dout_d = a_d[31:0];
         end
         S_WR_A1: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_A_HI;
            dout_d = a_d[63:32];
         end
         S_WR_B0: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_B_LO;
            dout_d = b_d[31:0];
         end
         S_WR_B1: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_B_HI;
            dout_d = b_d[63:32];
         end
         S_WR_IE: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_IE;
            dout_d = 32'd1;
         end
         S_START: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_START;
            dout_d = 32'd1;
         end
         S_RD: begin
            sel_d  = 1'b1;
            addr_d = ADDR_RES0 + {6'd0, rd_idx_d};
         end
         S_INTCLR: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_ICLR;
            dout_d = 32'd1;
         end
         S_ABORT: begin
            sel_d  = 1'b1;
            wr_d   = 1'b1;
            addr_d = ADDR_CLEAR;
            dout_d = 32'd1;
         end
         default: begin
            sel_d = 1'b0;
         end
      endcase
   end

   assign cmd_ready = cmd_ready_q;
   assign M_sel     = sel_q;
   assign M_wr      = wr_q;
   assign M_address = addr_q;
   assign M_dout    = dout_q;
   assign res_valid = res_valid_q;
   assign res_err   = res_err_q;
   assign res_data  = res_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_bus_master.sv
//==============================================================================
// tb_mul_bus_master - directed bench with a Multiplier slave model, expected
// bus-access and result queues, and literal checks on key results. Rev 1.0
//==============================================================================
`default_nettype none

module tb_mul_bus_master;

   localparam int TIMEOUT = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic [63:0]  cmd_a;
   logic [63:0]  cmd_b;
   logic         cmd_ready;
   logic         M_sel;
   logic         M_wr;
   logic [7:0]   M_address;
   logic [31:0]  M_dout;
   logic [31:0]  M_din = 32'd0;
   logic         m_interrupt;
   logic         res_valid;
   logic [127:0] res_data;
   logic         res_err;
   logic         res_ready;

   logic         irq_q = 1'b0;
   logic         spur;
   int           irq_delay = 0;
   int           irq_cnt = 0;
   logic [31:0]  sregs [0:15];

   assign m_interrupt = irq_q | spur;

   always #5 clk = ~clk;

   mul_bus_master #(.TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_ready  (cmd_ready),
      .M_sel      (M_sel),
      .M_wr       (M_wr),
      .M_address  (M_address),
      .M_dout     (M_dout),
      .M_din      (M_din),
      .m_interrupt(m_interrupt),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_err    (res_err),
      .res_ready  (res_ready)
   );

   // Multiplier slave: product on opstart, interrupt irq_delay cycles later (0 = never).
   always @(posedge clk) begin
      logic [127:0] p;
      if (M_sel && M_wr) begin
         sregs[M_address[3:0]] <= M_dout;
         if (M_address == 8'h08) begin
            p = {64'd0, sregs[3], sregs[2]} * {64'd0, sregs[1], sregs[0]};
            sregs[4] <= p[31:0];
            sregs[5] <= p[63:32];
            sregs[6] <= p[95:64];
            sregs[7] <= p[127:96];
            irq_q    <= 1'b0;
            irq_cnt  <= sregs[10][0] ? irq_delay : 0;
         end else if (M_address == 8'h0b) begin
            irq_q <= 1'b0;
         end
      end else if (irq_cnt > 0) begin
         irq_cnt <= irq_cnt - 1;
         if (irq_cnt == 1) irq_q <= 1'b1;
      end
      if (M_sel && !M_wr) M_din <= sregs[M_address[3:0]];
   end

   typedef struct packed {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
   } acc_t;

   acc_t         exp_bus[$];
   logic [128:0] exp_res[$];
   int           n_cmp = 0;
   int           n_bad = 0;
   bit           done = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic wr, input logic [7:0] a, input logic [31:0] d);
      acc_t e;
      e.wr   = wr;
      e.addr = a;
      e.data = d;
      exp_bus.push_back(e);
   endtask

   task automatic monitor();
      acc_t e;
      while (!done) begin
         @(negedge clk);
         if (!reset) begin
            if (M_sel) begin
               if (exp_bus.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL bus_extra: got access wr=%0d addr=%0h, required none", M_wr, M_address);
               end else begin
                  e = exp_bus.pop_front();
                  chk("bus_wr", 128'(M_wr), 128'(e.wr));
                  chk("bus_addr", 128'(M_address), 128'(e.addr));
                  if (e.wr) chk("bus_dout", 128'(M_dout), 128'(e.data));
               end
            end
            chk("ready_exclusive", 128'(cmd_ready & (M_sel | res_valid)), 128'(0));
            if (res_valid) begin
               if (exp_res.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL res_extra: got res_valid=1, required 0");
               end else begin
                  chk("res_data", res_data, exp_res[0][127:0]);
                  chk("res_err", 128'(res_err), 128'(exp_res[0][128]));
                  if (res_ready) void'(exp_res.pop_front());
               end
            end
         end
      end
   endtask

   task automatic start_op(input logic [63:0] a, input logic [63:0] b, input int d, input bit spur_wr);
      int lat;
      int n;
      push(1'b1, 8'h00, a[31:0]);
      push(1'b1, 8'h01, a[63:32]);
      push(1'b1, 8'h02, b[31:0]);
      push(1'b1, 8'h03, b[63:32]);
      push(1'b1, 8'h0a, 32'd1);
      push(1'b1, 8'h08, 32'd1);
      if (d > 0) begin
         for (int k = 0; k < 4; k++) push(1'b0, 8'(4 + k), 32'd0);
         push(1'b1, 8'h0b, 32'd1);
         exp_res.push_back({1'b0, {64'd0, a} * {64'd0, b}});
      end else begin
         push(1'b1, 8'h09, 32'd1);
         exp_res.push_back({1'b1, 128'd0});
      end
      irq_delay = d;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("cmd_ready_idle", 128'(cmd_ready), 128'(1));
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (!(M_sel && M_wr && M_address == 8'h08) && lat < 20) begin
         spur = spur_wr && (lat == 2);
         @(posedge clk); #1;
         lat++;
      end
      spur = 1'b0;
      chk("start_latency", 128'(lat), 128'(6));
   endtask

   task automatic finish_op(input int d, input int hold, output logic [127:0] got, output logic got_err);
      int w;
      int n;
      @(posedge clk); #1;
      w = 0;
      while (!M_sel && w < 200) begin
         w++;
         @(posedge clk); #1;
      end
      chk("wait_cycles", 128'(w), 128'((d > 0) ? d + 1 : TIMEOUT));
      n = 0;
      while (!res_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("out_latency", 128'(n), 128'((d > 0) ? 5 : 1));
      got     = res_data;
      got_err = res_err;
      for (int i = 0; i < hold; i++) begin
         cmd_valid = (i == 2);
         cmd_a     = 64'hdead_0000_dead;
         cmd_b     = 64'hbeef_0000_beef;
         chk("hold_cmd_ready", 128'(cmd_ready), 128'(0));
         chk("hold_res_valid", 128'(res_valid), 128'(1));
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("release_valid", 128'(res_valid), 128'(0));
      chk("release_err", 128'(res_err), 128'(0));
      chk("release_ready", 128'(cmd_ready), 128'(1));
   endtask

   initial begin
      logic [127:0] got;
      logic         ge;
      int           n;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;
      spur      = 1'b0;
      fork
         monitor();
         begin
            repeat (3) @(posedge clk);
            #1;
            chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
            chk("rst_sel", 128'(M_sel), 128'(0));
            chk("rst_wr", 128'(M_wr), 128'(0));
            chk("rst_addr", 128'(M_address), 128'(0));
            chk("rst_dout", 128'(M_dout), 128'(0));
            chk("rst_res_valid", 128'(res_valid), 128'(0));
            chk("rst_res_err", 128'(res_err), 128'(0));
            chk("rst_res_data", res_data, 128'(0));
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk); #1;
            chk("ready_after_reset", 128'(cmd_ready), 128'(1));

            spur = 1'b1;
            @(posedge clk); #1;
            spur = 1'b0;
            chk("idle_irq_no_sel", 128'(M_sel), 128'(0));
            @(posedge clk); #1;
            chk("idle_irq_no_sel2", 128'(M_sel), 128'(0));

            start_op(64'h20, 64'h19, 3, 1'b1);
            finish_op(3, 0, got, ge);
            chk("lit_small", got, 128'h320);
            chk("lit_small_err", 128'(ge), 128'(0));

            start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 20, 1'b0);
            finish_op(20, 10, got, ge);
            chk("lit_max", got, 128'hFFFFFFFFFFFFFFFE0000000000000001);

            start_op(64'h5, 64'h7, 0, 1'b0);
            finish_op(0, 2, got, ge);
            chk("lit_timeout_data", got, 128'd0);
            chk("lit_timeout_err", 128'(ge), 128'(1));

            start_op(64'h1_0000_0001, 64'h3, 63, 1'b0);
            finish_op(63, 0, got, ge);
            chk("lit_irq_wins", got, 128'h3_0000_0003);
            chk("lit_irq_wins_err", 128'(ge), 128'(0));

            start_op(64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 1, 1'b0);
            finish_op(1, 0, got, ge);
            start_op(64'hffff_0000_ffff_0000, 64'h0000_ffff_0000_ffff, 5, 1'b0);
            finish_op(5, 0, got, ge);

            start_op(64'h1_0000_0002, 64'h2_0000_0003, 4, 1'b0);
            n = 0;
            while (!(M_sel && !M_wr && M_address == 8'h07) && n < 100) begin
               @(posedge clk); #1;
               n++;
            end
            chk("reached_rd_word3", 128'(M_address), 128'h07);
            chk("partial_capture", res_data, 128'h7_0000_0006);
            reset = 1'b1;
            #1;
            chk("midrd_sel", 128'(M_sel), 128'(0));
            chk("midrd_res_valid", 128'(res_valid), 128'(0));
            chk("midrd_res_data", res_data, 128'(0));
            chk("midrd_cmd_ready", 128'(cmd_ready), 128'(0));
            exp_bus.delete();
            exp_res.delete();
            @(negedge clk);
            reset = 1'b0;
            @(posedge clk); #1;
            start_op(64'h1_0000_0002, 64'h2_0000_0003, 4, 1'b0);
            finish_op(4, 0, got, ge);
            chk("lit_after_reset", got, 128'h2_0000_0007_0000_0006);

            repeat (3) @(posedge clk);
            #1;
            chk("exp_bus_drained", 128'(exp_bus.size()), 128'(0));
            chk("exp_res_drained", 128'(exp_res.size()), 128'(0));
            done = 1'b1;
         end
      join
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
